// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  localparam int         PC_INC     = 4;
  localparam logic [1:0] ALIGN_MASK = 2'h3;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_unit_ras.sv
// Return-address stack: circular storage with a saturating depth count,
// so overflow silently overwrites the oldest entry.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] mem_reg [RAS_DEPTH];
  logic [PW-1:0]   ptr_reg;
  logic [PW:0]     count_reg;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic            do_pop;

  assign top_idx = ptr_reg - PW'(1);
  assign top     = mem_reg[top_idx];
  assign empty   = (count_reg == '0);
  // A pop on an empty stack is dropped; push+pop rewrites the top in place.
  assign do_pop  = pop & ~empty;
  assign wr_idx  = do_pop ? top_idx : ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push && !do_pop) begin
      ptr_reg <= ptr_reg + PW'(1);
      if (count_reg != (PW+1)'(RAS_DEPTH))
        count_reg <= count_reg + (PW+1)'(1);
    end else if (do_pop && !push) begin
      ptr_reg   <= ptr_reg - PW'(1);
      count_reg <= count_reg - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage PC generator: boot/run/halt control, priority next-PC mux, fetch handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_req,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);
  pc_state_t       state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misalign_reg, misalign_next;
  logic            advance;
  logic            ras_hit;
  logic [XLEN-1:0] ras_top;

  assign pc           = pc_reg;
  assign pc_plus4     = pc_reg + XLEN'(PC_INC);
  assign pc_valid     = (state_reg == ST_RUN);
  assign misalign_err = misalign_reg;
  assign advance      = pc_valid & fetch_ready & ~stall;

`ifdef PC_RAS_EN
  logic ras_empty;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (advance & call_push),
    .pop       (advance & ret_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign ras_hit = ret_pop & ~ras_empty;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;

  assign unused_ras_inputs = call_push ^ ret_pop;
  assign ras_top           = '0;
  assign ras_hit           = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      // Leave RUN only once the outstanding request has been accepted.
      ST_RUN:  if (halt_req && (!pc_valid || fetch_ready)) state_next = ST_HALT;
      ST_HALT: if (!halt_req) state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_next       = pc_reg;
    misalign_next = 1'b0;
    // Flushes override stall/backpressure/halt, but not the boot cycle.
    if (state_reg != ST_BOOT) begin
      if (trap_valid) begin
        pc_next = TRAP_VEC;
      end else if (redirect_valid && is_misaligned(redirect_pc[1:0])) begin
        pc_next       = TRAP_VEC;
        misalign_next = 1'b1;
      end else if (redirect_valid) begin
        pc_next = redirect_pc;
      end else if (advance) begin
        pc_next = ras_hit ? ras_top : pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_VEC;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      misalign_reg <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_req, fetch_ready, stall, redirect_valid, trap_valid;
  logic        call_push, ret_pop;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_plus4;
  logic        pc_valid, misalign_err;

  int errors = 0;
  int checks = 0;

  pc_gen_unit dut (
    .clk            (clk),
    .rst            (rst),
    .halt_req       (halt_req),
    .fetch_ready    (fetch_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .call_push      (call_push),
    .ret_pop        (ret_pop),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pc_plus4       (pc_plus4),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: booted/halted flags, expected pc, and a bounded LIFO.
  bit          m_booted, m_halted, m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_booted = 0; m_halted = 0; m_mis = 0; m_pc = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    bit          valid = m_booted && !m_halted;
    bit          acc   = valid && fetch_ready && !stall;
    logic [31:0] nxt   = m_pc;
    bit          mis   = 0;
    if (m_booted) begin
      if (trap_valid) nxt = 32'h100;
      else if (redirect_valid && (redirect_pc % 4 != 0)) begin nxt = 32'h100; mis = 1; end
      else if (redirect_valid) nxt = redirect_pc;
      else if (acc) begin
        nxt = m_pc + 32'd4;
`ifdef PC_RAS_EN
        if (ret_pop && m_ras.size() > 0) nxt = m_ras[$];
`endif
      end
    end
`ifdef PC_RAS_EN
    if (acc) begin
      if (ret_pop && m_ras.size() > 0) void'(m_ras.pop_back());
      if (call_push) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
`endif
    if (!m_booted) m_booted = 1;
    else if (!m_halted) begin if (halt_req && fetch_ready) m_halted = 1; end
    else if (!halt_req) m_halted = 0;
    m_pc  = nxt;
    m_mis = mis;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    halt_req = 0; fetch_ready = 0; stall = 0; redirect_valid = 0;
    redirect_pc = 32'h0; trap_valid = 0; call_push = 0; ret_pop = 0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk); #1;
    chk({tag, ".pc"},       pc,                   m_pc);
    chk({tag, ".valid"},    {31'b0, pc_valid},     {31'b0, m_booted && !m_halted});
    chk({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, m_mis});
    chk({tag, ".plus4"},    pc_plus4,             m_pc + 32'd4);
    $display("%0t %s pc=%h valid=%0b mis=%0b", $time, tag, pc, pc_valid, misalign_err);
  endtask

  typedef struct {
    logic        halt, ready, stall, rv;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] exp_pc;
    logic        exp_valid, exp_mis;
  } vec_t;

  vec_t vecs[16];
  logic [31:0] held;
  logic [31:0] pop_exp[5];

  initial begin
    // halt ready stall rv rpc trap | pc valid mis
    vecs[0]  = '{0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 0};
    vecs[1]  = '{0, 1, 0, 0, 32'h0,   0, 32'h4,   1, 0};
    vecs[2]  = '{0, 1, 0, 0, 32'h0,   0, 32'h8,   1, 0};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,   0, 32'h8,   1, 0};
    vecs[4]  = '{0, 0, 0, 0, 32'h0,   0, 32'h8,   1, 0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,   0, 32'h8,   1, 0};
    vecs[6]  = '{0, 1, 0, 0, 32'h0,   0, 32'hC,   1, 0};
    vecs[7]  = '{0, 1, 0, 0, 32'h0,   0, 32'h10,  1, 0};
    vecs[8]  = '{0, 1, 1, 1, 32'h200, 0, 32'h200, 1, 0};
    vecs[9]  = '{0, 1, 1, 0, 32'h0,   0, 32'h200, 1, 0};
    vecs[10] = '{0, 1, 0, 0, 32'h0,   0, 32'h204, 1, 0};
    vecs[11] = '{0, 1, 0, 1, 32'h300, 1, 32'h100, 1, 0};
    vecs[12] = '{0, 1, 0, 1, 32'h302, 0, 32'h100, 1, 1};
    vecs[13] = '{0, 1, 0, 0, 32'h0,   0, 32'h104, 1, 0};
    vecs[14] = '{0, 0, 0, 1, 32'h300, 0, 32'h300, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 32'h0,   0, 32'h304, 1, 0};

    idle();
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.pc",    pc,                   32'h0);
    chk("reset.valid", {31'b0, pc_valid},     32'h0);
    chk("reset.mis",   {31'b0, misalign_err}, 32'h0);
    rst = 1;

    // Directed table: boot, backpressure, stall vs redirect, priority, misalign.
    for (int i = 0; i < 16; i++) begin
      halt_req = vecs[i].halt; fetch_ready = vecs[i].ready; stall = vecs[i].stall;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc; trap_valid = vecs[i].trap;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tab_pc", i),    pc,                   vecs[i].exp_pc);
      chk($sformatf("vec%0d.tab_valid", i), {31'b0, pc_valid},     {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.tab_mis", i),   {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
    end

    // Wrap at the top of the address space.
    idle(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step("wrap_load");
    chk("wrap.plus4", pc_plus4, 32'h0);
    idle(); fetch_ready = 1;
    step("wrap_adv");
    chk("wrap.pc", pc, 32'h0);

    // Halt waits for backpressure to clear, then freezes pc until released.
    idle(); halt_req = 1;
    step("halt_pending");
    chk("halt_pending.valid", {31'b0, pc_valid}, 32'h1);
    fetch_ready = 1;
    step("halt_enter");
    chk("halt_enter.valid", {31'b0, pc_valid}, 32'h0);
    held = pc;
    step("halt_hold1");
    step("halt_hold2");
    chk("halt_hold.pc", pc, held);
    halt_req = 0;
    step("halt_release");
    chk("halt_release.pc", pc, held);
    chk("halt_release.valid", {31'b0, pc_valid}, 32'h1);
    step("halt_resume");
    chk("halt_resume.pc", pc, held + 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      halt_req       = ($urandom_range(0, 9) == 0);
      fetch_ready    = ($urandom_range(0, 9) < 7);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      trap_valid     = ($urandom_range(0, 29) == 0);
      call_push      = ($urandom_range(0, 6) == 0);
      ret_pop        = ($urandom_range(0, 6) == 0);
      step($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-run at pc=0x40.
    idle(); redirect_valid = 1; redirect_pc = 32'h40;
    step("pre_reset");
    chk("pre_reset.pc", pc, 32'h40);
    idle();
    #2 rst = 0;
    #1;
    model_reset();
    chk("async_reset.pc",    pc,               32'h0);
    chk("async_reset.valid", {31'b0, pc_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    chk("reset_released.valid", {31'b0, pc_valid}, 32'h0);
    fetch_ready = 1;
    step("boot_edge");
    chk("boot_edge.valid", {31'b0, pc_valid}, 32'h1);
    chk("boot_edge.pc",    pc,                32'h0);
    step("first_adv");
    chk("first_adv.pc", pc, 32'h4);

`ifdef PC_RAS_EN
    idle(); redirect_valid = 1; redirect_pc = 32'h10;
    step("ras_goto10");
    idle(); fetch_ready = 1; call_push = 1;
    step("ras_call");
    chk("ras_call.pc", pc, 32'h14);
    call_push = 0;
    step("ras_seq1");
    step("ras_seq2");
    ret_pop = 1;
    step("ras_ret");
    chk("ras_ret.pc", pc, 32'h14);
    idle(); redirect_valid = 1; redirect_pc = 32'h1000;
    step("ras_goto1000");
    idle(); fetch_ready = 1; call_push = 1;
    for (int i = 0; i < 5; i++) step($sformatf("ras_push%0d", i));
    call_push = 0; ret_pop = 1;
    pop_exp[0] = 32'h1014; pop_exp[1] = 32'h1010; pop_exp[2] = 32'h100C;
    pop_exp[3] = 32'h1008; pop_exp[4] = 32'h100C;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("ras_pop%0d", i));
      chk($sformatf("ras_pop%0d.const", i), pc, pop_exp[i]);
    end
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
